// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix pins plus CPU read port.
// The scanner takes the slave side.
interface keypad_scanner_if;
  logic [3:0]  col_read;
  logic [3:0]  row_write;
  logic        readyclr;
  logic        a0;
  logic [15:0] dataout;
  logic        ready;

  modport master (
    output col_read,
    output readyclr,
    output a0,
    input  row_write,
    input  dataout,
    input  ready
  );

  modport slave (
    input  col_read,
    input  readyclr,
    input  a0,
    output row_write,
    output dataout,
    output ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce.
// Holds last key code and a ready flag for the CPU.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DB_TICKS = 10
) (
  input logic           clk,
  input logic           rst_n,
  keypad_scanner_if.slave bus
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_TOP = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DB_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [3:0]    col_s1;
  logic [3:0]    colq;
  logic [1:0]    r;
  logic [1:0]    c;
  logic [3:0]    cnt;
  logic [3:0]    keycode;
  logic          ready;

  logic       tick;
  logic       hit;
  logic       same;
  logic [1:0] col_now;
  logic [3:0] cnt_inc;

  function automatic logic [1:0] low_col(
    input logic [3:0] q
  );
    if (!q[0])      return 2'd0;
    else if (!q[1]) return 2'd1;
    else if (!q[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(
    input logic [1:0] rr,
    input logic [1:0] cc
  );
    logic [3:0] k;
    unique case ({rr, cc})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  assign tick    = (div == DIV_TOP);
  assign hit     = (colq != 4'hF);
  assign col_now = low_col(colq);
  assign same    = hit && (col_now == c);
  assign cnt_inc = cnt + 4'd1;

  assign bus.row_write = ~(4'b0001 << r);
  assign bus.ready     = ready;
  assign bus.dataout   = bus.a0 ? {15'b0, ready}
                                : {12'b0, keycode};

  // Free-running scan divider; wraps to produce the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  // Two-flop column synchroniser, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      colq   <= 4'hF;
    end else begin
      col_s1 <= bus.col_read;
      colq   <= col_s1;
    end
  end

  // Scan/debounce FSM; acceptance beats readyclr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      r       <= 2'd0;
      c       <= 2'd0;
      cnt     <= 4'd0;
      keycode <= 4'd0;
      ready   <= 1'b0;
    end else begin
      if (bus.readyclr) ready <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (hit) begin
              c     <= col_now;
              cnt   <= 4'd1;
              state <= DEBOUNCE;
            end else begin
              r <= r + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (same) begin
              if (cnt_inc >= DB) begin
                keycode <= key_map(r, c);
                ready   <= 1'b1;
                cnt     <= 4'd0;
                state   <= HELD;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= 4'd0;
              state <= SCAN;
            end
          end
          HELD: begin
            if (hit) begin
              cnt <= 4'd0;
            end else if (cnt_inc >= DB) begin
              cnt   <= 4'd0;
              r     <= r + 2'd1;
              state <= SCAN;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// SCAN_DIV=4, DB_TICKS=3 with a matrix key model.
module tb_keypad_scanner;

  logic clk;
  logic rst_n;
  logic [3:0] keys [4];

  int checks;
  int failures;

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DB_TICKS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key model: pressed key grounds its column while its row is low.
  always_comb begin
    bus.col_read = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (!bus.row_write[i])
        bus.col_read = bus.col_read & ~keys[i];
    end
  end

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [15:0] code;
  } vec_t;

  vec_t vecs [16];

  task automatic check(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 4; i++) keys[i] = 4'h0;
  endtask

  task automatic wait_ready(
    input string name,
    input int    max
  );
    int n;
    n = 0;
    while (!bus.ready && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'b0, bus.ready}, 16'h0001);
  endtask

  task automatic wait_row_enter(
    input string      name,
    input logic [3:0] target
  );
    int n;
    n = 0;
    while (bus.row_write == target && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (bus.row_write != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {12'b0, bus.row_write}, {12'b0, target});
  endtask

  task automatic status(
    input string       name,
    input logic [15:0] exp
  );
    bus.a0 = 1'b1;
    #1;
    check(name, bus.dataout, exp);
    bus.a0 = 1'b0;
    #1;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.readyclr = 1'b1;
    @(negedge clk);
    bus.readyclr = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [4];
    int n;

    checks   = 0;
    failures = 0;
    rst_n        = 1'b0;
    bus.a0       = 1'b0;
    bus.readyclr = 1'b0;
    clear_keys();

    vecs[0]  = '{2'd0, 2'd0, 16'h0001};
    vecs[1]  = '{2'd0, 2'd1, 16'h0002};
    vecs[2]  = '{2'd0, 2'd2, 16'h0003};
    vecs[3]  = '{2'd0, 2'd3, 16'h000A};
    vecs[4]  = '{2'd1, 2'd0, 16'h0004};
    vecs[5]  = '{2'd1, 2'd1, 16'h0005};
    vecs[6]  = '{2'd1, 2'd2, 16'h0006};
    vecs[7]  = '{2'd1, 2'd3, 16'h000B};
    vecs[8]  = '{2'd2, 2'd0, 16'h0007};
    vecs[9]  = '{2'd2, 2'd1, 16'h0008};
    vecs[10] = '{2'd2, 2'd2, 16'h0009};
    vecs[11] = '{2'd2, 2'd3, 16'h000C};
    vecs[12] = '{2'd3, 2'd0, 16'h000E};
    vecs[13] = '{2'd3, 2'd1, 16'h0000};
    vecs[14] = '{2'd3, 2'd2, 16'h000F};
    vecs[15] = '{2'd3, 2'd3, 16'h000D};

    seq[0] = 4'b1101;
    seq[1] = 4'b1011;
    seq[2] = 4'b0111;
    seq[3] = 4'b1110;

    // Reset state and idle row rotation
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_row", {12'b0, bus.row_write}, 16'h000E);
    check("rst_ready", {15'b0, bus.ready}, 16'h0000);
    check("rst_data", bus.dataout, 16'h0000);
    status("rst_status", 16'h0000);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("scan_row%0d", i),
            {12'b0, bus.row_write}, {12'b0, seq[i]});
    end

    // Hold key r1,c2
    keys[1] = 4'b0100;
    wait_ready("r1c2_ready", 150);
    check("r1c2_data", bus.dataout, 16'h0006);
    status("r1c2_status", 16'h0001);

    // Clear while held: no re-trigger, then resume from row2
    clr_pulse();
    check("clr_ready", {15'b0, bus.ready}, 16'h0000);
    repeat (40) @(negedge clk);
    check("held_no_rep", {15'b0, bus.ready}, 16'h0000);
    check("held_row", {12'b0, bus.row_write}, 16'h000D);
    keys[1] = 4'b0000;
    n = 0;
    while (bus.row_write == 4'b1101 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resume_row2", {12'b0, bus.row_write}, 16'h000B);

    // Full key map
    for (int i = 0; i < 16; i++) begin
      keys[vecs[i].row][vecs[i].col] = 1'b1;
      wait_ready($sformatf("map%0d_ready", i), 150);
      check($sformatf("map%0d_code", i),
            bus.dataout, vecs[i].code);
      clr_pulse();
      clear_keys();
      repeat (40) @(negedge clk);
      check($sformatf("map%0d_idle", i),
            {15'b0, bus.ready}, 16'h0000);
    end

    // Bounce on r3,c1: low 1 tick, high 1 tick, low 3 ticks
    wait_row_enter("bnc_sync", 4'b0111);
    keys[3] = 4'b0010;
    repeat (4) @(negedge clk);
    keys[3] = 4'b0000;
    repeat (4) @(negedge clk);
    keys[3] = 4'b0010;
    repeat (11) @(negedge clk);
    check("bnc_pre", {15'b0, bus.ready}, 16'h0000);
    @(negedge clk);
    check("bnc_ready", {15'b0, bus.ready}, 16'h0001);
    check("bnc_code", bus.dataout, 16'h0000);
    status("bnc_status", 16'h0001);
    clr_pulse();
    repeat (20) @(negedge clk);
    check("bnc_once", {15'b0, bus.ready}, 16'h0000);
    keys[3] = 4'b0000;

    // Two keys on row0: lowest column wins, accept beats clear
    wait_row_enter("multi_sync", 4'b1110);
    keys[0] = 4'b1010;
    repeat (11) @(negedge clk);
    check("multi_pre", {15'b0, bus.ready}, 16'h0000);
    bus.readyclr = 1'b1;
    @(negedge clk);
    bus.readyclr = 1'b0;
    check("multi_win", {15'b0, bus.ready}, 16'h0001);
    check("multi_code", bus.dataout, 16'h0002);

    // New key while ready=1 overwrites keycode
    keys[0] = 4'b0000;
    repeat (40) @(negedge clk);
    keys[2] = 4'b0100;
    n = 0;
    while (bus.dataout != 16'h0009 && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("ovw_code", bus.dataout, 16'h0009);
    check("ovw_ready", {15'b0, bus.ready}, 16'h0001);
    keys[2] = 4'b0000;
    repeat (40) @(negedge clk);

    // Reset during debounce of r2,c0
    wait_row_enter("rdb_sync", 4'b1011);
    keys[2] = 4'b0001;
    repeat (5) @(negedge clk);
    check("rdb_hold", {12'b0, bus.row_write}, 16'h000B);
    rst_n = 1'b0;
    #1;
    check("rdb_row", {12'b0, bus.row_write}, 16'h000E);
    check("rdb_ready", {15'b0, bus.ready}, 16'h0000);
    check("rdb_code", bus.dataout, 16'h0000);
    keys[2] = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rdb_noacc", {15'b0, bus.ready}, 16'h0000);
    wait_row_enter("rdb_scan", 4'b1101);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
